// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the memory/IO bus arbiter.
// State encoding and the data word returned on an aborted access.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for any practical DW; the top slices off DW bits.
  localparam int unsigned      ERR_DATA_MAX_W = 1024;
  localparam logic [ERR_DATA_MAX_W-1:0] ERR_DATA = '1;

  localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/mio_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the last grant
// and wraps, so the last winner has the lowest priority.
module rr_pick #(
  parameter int N_CPU = 2,
  parameter int GW    = $clog2(N_CPU)
) (
  input  logic [N_CPU-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    next,
  output logic             valid
);

  always_comb begin
    next  = last;
    valid = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = N_CPU; k >= 1; k--) begin
      if (req[GW'((int'(last) + k) % N_CPU)]) begin
        next  = GW'((int'(last) + k) % N_CPU);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Round-robin arbiter granting N_CPU requesters one at a time onto a single
// memory/IO bus. Define MIO_ARB_TIMEOUT_EN to abort stalled bus accesses.
module mio_arbiter
  import mio_arb_pkg::*;
#(
  parameter int N_CPU       = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CPU-1:0]       cpu_req,
  input  logic [N_CPU-1:0]       cpu_we,
  input  logic [N_CPU*AW-1:0]    cpu_addr,
  input  logic [N_CPU*DW-1:0]    cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic [N_CPU-1:0]       cpu_ready,
  output logic                   cpu_err,
  output logic                   CPU_MIO,
  output logic                   mem_w,
  output logic [AW-1:0]          Addr_out,
  output logic [DW-1:0]          Data_out,
  input  logic [DW-1:0]          Data_in,
  input  logic                   MIO_ready,
  output logic [$clog2(N_CPU)-1:0] grant_id
);

  localparam int GW = $clog2(N_CPU);

  if (N_CPU < 2 || N_CPU > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("mio_arbiter: N_CPU or TIMEOUT_CYC out of range");
  end

  state_t          state;
  logic [GW-1:0]   pick_id;
  logic            pick_vld;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_pick #(
    .N_CPU (N_CPU),
    .GW    (GW)
  ) u_rr_pick (
    .req   (cpu_req),
    .last  (grant_id),
    .next  (pick_id),
    .valid (pick_vld)
  );

  // Request fields of the CPU the picker chose this cycle.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (GW'(i) == pick_id) begin
        sel_we    = cpu_we[i];
        sel_addr  = cpu_addr[i*AW +: AW];
        sel_wdata = cpu_wdata[i*DW +: DW];
      end
    end
  end

`ifdef MIO_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 cpu_err_r;

  assign cpu_err = cpu_err_r;
`else
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      CPU_MIO   <= 1'b0;
      mem_w     <= 1'b0;
      Addr_out  <= '0;
      Data_out  <= '0;
      cpu_ready <= '0;
      cpu_rdata <= '0;
      grant_id  <= GW'(N_CPU - 1);
`ifdef MIO_ARB_TIMEOUT_EN
      cpu_err_r <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            mem_w    <= sel_we;
            Addr_out <= sel_addr;
            Data_out <= sel_wdata;
            CPU_MIO  <= 1'b1;
            state    <= BUS;
`ifdef MIO_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end

        // Bus fields stay frozen here; only completion or timeout leaves.
        BUS: begin
          if (MIO_ready) begin
            if (!mem_w) cpu_rdata <= Data_in;
            cpu_ready <= N_CPU'(1) << grant_id;
            CPU_MIO   <= 1'b0;
            state     <= RESP;
`ifdef MIO_ARB_TIMEOUT_EN
            cpu_err_r <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            cpu_rdata <= ERR_DATA[DW-1:0];
            cpu_err_r <= 1'b1;
            cpu_ready <= N_CPU'(1) << grant_id;
            CPU_MIO   <= 1'b0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        RESP: begin
          cpu_ready <= '0;
`ifdef MIO_ARB_TIMEOUT_EN
          cpu_err_r <= 1'b0;
`endif
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 SHALL have parameter N_CPU, default 2, number of requesting CPU ports (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, bus wait limit in cycles (1..65535).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cpu_req  input  N_CPU  per-CPU access request, held until cpu_ready.
REQ-008 SHALL have port cpu_we  input  N_CPU  per-CPU write enable (1 = write).
REQ-009 SHALL have port cpu_addr  input  N_CPU*AW  packed per-CPU address, CPU i at [i*AW +: AW].
REQ-010 SHALL have port cpu_wdata  input  N_CPU*DW  packed per-CPU write data.
REQ-011 SHALL have port cpu_rdata  output  DW  read data, shared, valid with cpu_ready.
REQ-012 SHALL have port cpu_ready  output  N_CPU  one-cycle completion pulse to granted CPU.
REQ-013 SHALL have port cpu_err  output  1  access aborted by timeout, valid with cpu_ready.
REQ-014 SHALL have port CPU_MIO  output  1  bus request to memory/IO system.
REQ-015 SHALL have port mem_w  output  1  bus write strobe, qualified by CPU_MIO.
REQ-016 SHALL have port Addr_out  output  AW  bus address.
REQ-017 SHALL have port Data_out  output  DW  bus write data.
REQ-018 SHALL have port Data_in  input  DW  bus read data, sampled when MIO_ready=1.
REQ-019 SHALL have port MIO_ready  input  1  bus completion handshake.
REQ-020 SHALL have port grant_id  output  $clog2(N_CPU)  index of last/current granted CPU.

Function
REQ-021 SHALL implement FSM states IDLE, BUS, RESP.
REQ-022 IDLE: if any cpu_req set, SHALL pick CPU by round-robin starting at grant_id+1 (wrapping at N_CPU), latch its we/addr/wdata, update grant_id, go BUS; else stay IDLE.
REQ-023 BUS: SHALL drive CPU_MIO=1, mem_w, Addr_out, Data_out from registers, stable for the whole state.
REQ-024 BUS with MIO_ready=1: SHALL latch Data_in (reads only; writes hold previous value) and go RESP.
REQ-025 RESP: SHALL pulse cpu_ready[grant_id]=1 for exactly one cycle with cpu_rdata valid, CPU_MIO=0, then go IDLE.
REQ-026 Latency: request seen in IDLE cycle n -> CPU_MIO=1 at n+1; MIO_ready at cycle k -> cpu_ready at k+1.
REQ-027 Minimum spacing between grants SHALL be 3 cycles; back-to-back requests from one CPU SHALL yield to any other pending CPU.
REQ-028 MIO_ready outside BUS SHALL be ignored.
REQ-029 cpu_req deasserted during BUS SHALL NOT abort the access; cpu_ready still pulses.
REQ-030 cpu_req with no valid index (N_CPU non-power-of-2) SHALL never be granted.

Reset
REQ-031 On reset=1 at a clock edge: state IDLE, CPU_MIO=0, mem_w=0, Addr_out=0, Data_out=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, grant_id=N_CPU-1 (so CPU 0 wins first).
REQ-032 Reset during BUS SHALL abandon the access with no cpu_ready pulse.

Configuration
REQ-033 With MIO_ARB_TIMEOUT_EN defined: BUS SHALL count cycles; after TIMEOUT_CYC cycles without MIO_ready, go RESP with cpu_err=1 and cpu_rdata all ones.
REQ-034 Without MIO_ARB_TIMEOUT_EN: no counter, BUS waits indefinitely, cpu_err tied 0.

Structure
REQ-035 Package mio_arb_pkg SHALL hold the state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the all-ones error data constant.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick (request vector + last grant -> next grant + valid), combinational.

Verification
REQ-037 Reset, then cpu_req=2'b01, we=0, addr0=0x100, MIO_ready at 3rd BUS cycle with Data_in=0xDEADBEEF -> Addr_out=0x100, mem_w=0, cpu_ready=2'b01 one cycle, cpu_rdata=0xDEADBEEF.
REQ-038 cpu_req=2'b11 held continuously, MIO_ready=1 always -> grants alternate 0,1,0,1; each cpu_ready pulse 3 cycles apart.
REQ-039 CPU1 write, wdata=0x12345678, addr=0x200 -> CPU_MIO=1, mem_w=1, Data_out=0x12345678 stable until MIO_ready.
REQ-040 MIO_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, MIO_ready never -> cpu_ready after 4 BUS cycles, cpu_err=1, cpu_rdata=0xFFFFFFFF; without macro, CPU_MIO stays 1 for 100 cycles.
REQ-041 reset asserted in 2nd BUS cycle -> next cycle CPU_MIO=0, no cpu_ready, next grant to CPU 0.
REQ-042 N_CPU=3, cpu_req=3'b111, MIO_ready=1 -> grant order 0,1,2,0 (wrap).
